dbus_ram_resp: RTL and testbench

DBUS_RAM_RESP -- requirements
Module: dbus_ram_resp

---
 rtl/dbus_pkg.sv | 26 ++
 rtl/dbus_ram_bank.sv | 36 +++
 rtl/dbus_ram_resp.sv | 114 +++++++++++
 tb/tb_dbus_ram_resp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and constants for the data-bus RAM responder.
// Optional feature macro: DBUS_RESP_ERR_EN (out-of-range error response).
package dbus_pkg;

  localparam int          MASK_W        = 4;
  localparam logic [31:0] DBUS_BASE_DEF = 32'h8000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [MASK_W-1:0] mask;
  } dbus_req_t;

  function automatic logic [31:0] dbus_off(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr - base;
  endfunction

endpackage

// File: rtl/dbus_ram_bank.sv
// dbus_ram_bank: byte-lane writable synchronous word array.
// One port: a read or a masked write per enabled cycle.
module dbus_ram_bank
  import dbus_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [31:0]       wdata_i,
  input  logic [MASK_W-1:0] be_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage is never reset; reads are registered.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_ram_resp.sv
// dbus_ram_resp: fixed-latency RAM responder on a req/ready data bus.
// Optional feature macro: DBUS_RESP_ERR_EN (error on out-of-range address).
module dbus_ram_resp
  import dbus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DBUS_BASE_DEF,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic              I_we,
  input  logic [31:0]       I_addr,
  input  logic [31:0]       I_wdata,
  input  logic [MASK_W-1:0] I_mask,
  output logic [31:0]       O_rdata,
  output logic              O_ready,
  output logic              O_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dbus_req_t   req_q, req_d;

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        inr;
  logic        in_resp;
  logic        enter_resp;
  logic        bank_en;
  logic        bank_we;
  logic [31:0] bank_rdata;
  logic        unused_off;

  // Next-state: accept in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (I_req) begin
          req_d.we    = I_we;
          req_d.addr  = I_addr;
          req_d.wdata = I_wdata;
          req_d.mask  = I_mask;
          cnt_d       = 4'(WAIT_CYCLES);
          state_d     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // req_d equals req_q outside IDLE, so one decode serves both the
  // read issued on entry to RESP and the write at the end of RESP.
  assign off = dbus_off(req_d.addr, BASE_ADDR);
  assign idx = off[AW+1:2];
  assign unused_off = ^{off[1:0], off[31:AW+2]};

`ifdef DBUS_RESP_ERR_EN
  assign inr = (off[31:AW+2] == '0);
`else
  assign inr = 1'b1;
`endif

  assign in_resp    = (state_q == S_RESP);
  assign enter_resp = (state_d == S_RESP) && !in_resp;
  assign bank_we    = in_resp && req_q.we && inr;
  assign bank_en    = bank_we || (enter_resp && !req_d.we && inr);

  dbus_ram_bank #(
    .DEPTH(DEPTH_WORDS)
  ) u_bank (
    .clk    (clk),
    .en_i   (bank_en),
    .we_i   (bank_we),
    .idx_i  (idx),
    .wdata_i(req_q.wdata),
    .be_i   (req_q.mask),
    .rdata_o(bank_rdata)
  );

  assign O_ready = in_resp;
  assign O_rdata = (in_resp && !req_q.we && inr) ? bank_rdata : 32'h0;

`ifdef DBUS_RESP_ERR_EN
  assign O_err = in_resp && !inr;
`else
  assign O_err = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_ram_resp.sv
// tb_dbus_ram_resp: randomized bench with a word-array reference model.
// Honors DBUS_RESP_ERR_EN for out-of-range expectations.
module tb_dbus_ram_resp;
  import dbus_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic I_req = 0, I_we = 0;
  logic [31:0] I_addr = 0, I_wdata = 0;
  logic [3:0] I_mask = 0;
  logic [31:0] O_rdata;
  logic O_ready, O_err;

  logic req0 = 0;
  logic [31:0] rdata0;
  logic ready0, err0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  dbus_ram_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .I_req(I_req), .I_we(I_we), .I_addr(I_addr),
    .I_wdata(I_wdata), .I_mask(I_mask), .O_rdata(O_rdata),
    .O_ready(O_ready), .O_err(O_err));

  dbus_ram_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .I_req(req0), .I_we(1'b0), .I_addr(BASE),
    .I_wdata(32'h0), .I_mask(4'h0), .O_rdata(rdata0),
    .O_ready(ready0), .O_err(err0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; starts and ends at a negedge with the DUT idle.
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask,
                     output logic [31:0] rd, output logic er, output int lat);
    bit got = 0;
    bit quiet = 1;
    I_req = 1; I_we = we; I_addr = addr; I_wdata = wdata; I_mask = mask;
    rd = 'x; er = 'x; lat = -1;
    @(posedge clk);
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      I_addr = $urandom; I_wdata = $urandom; I_mask = 4'($urandom);
      I_we = 1'($urandom);
      if (O_ready) begin
        got = 1; lat = n; rd = O_rdata; er = O_err; I_req = 0;
      end else if (O_rdata !== 0 || O_err !== 0) begin
        quiet = 0;
      end
    end
    I_req = 0;
    chk("idle_outputs_zero", 32'(quiet), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Spec-level reference: offset, range test, modulo wrap, byte merge.
  task automatic op(input logic we, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [3:0] mask,
                    output logic [31:0] rd);
    logic [31:0] off, exp_rd;
    logic er, exp_er;
    int lat, idx;
    bit inr;
    off = addr - BASE;
    inr = (off < 32'(4 * DEPTH));
    idx = int'((off >> 2) % DEPTH);
    exp_er = 0; exp_rd = 0;
`ifdef DBUS_RESP_ERR_EN
    if (!inr) exp_er = 1;
`else
    inr = 1;
`endif
    txn(we, addr, wdata, mask, rd, er, lat);
    if (inr) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = mdl[idx];
      end
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("err", 32'(er), 32'(exp_er));
    chk(we ? "wr_rdata" : "rd_rdata", rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int pulses;
    bit pat_ok;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(O_ready), 32'd0);
    chk("rst_err", 32'(O_err), 32'd0);
    chk("rst_rdata", O_rdata, 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) op(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rd);

    op(1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, rd);
    op(1'b0, 32'h8000_0010, 32'h0, 4'hF, rd);
    chk("raw_value", rd, 32'hDEADBEEF);
    op(1'b1, 32'h8000_0010, 32'h0000_55AA, 4'b0011, rd);
    op(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);
    chk("partial_value", rd, 32'hDEAD55AA);

    op(1'b1, 32'h8000_0000, 32'hA5A5_0001, 4'hF, rd);
    op(1'b0, 32'h8000_1000, 32'h0, 4'hF, rd);
`ifdef DBUS_RESP_ERR_EN
    chk("oor_rdata", rd, 32'h0);
`else
    chk("oor_wrap", rd, 32'hA5A5_0001);
`endif

    op(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, rd);
    I_req = 1; I_we = 1; I_addr = 32'h8000_0020;
    I_wdata = 32'h1234_5678; I_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 0; I_req = 0;
    #1;
    chk("midrst_ready", 32'(O_ready), 32'd0);
    @(negedge clk);
    rst = 1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (O_ready) pulses++;
    end
    chk("midrst_no_ready", 32'(pulses), 32'd0);
    op(1'b0, 32'h8000_0020, 32'h0, 4'hF, rd);
    chk("midrst_prior", rd, 32'h0BAD_F00D);

    req0 = 1;
    pulses = 0;
    pat_ok = 1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready0) pulses++;
      if (ready0 !== ((i % 2) == 0)) pat_ok = 0;
      if (err0 !== 1'b0) pat_ok = 0;
      if (i == 7) req0 = 0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_pattern", 32'(pat_ok), 32'd1);

    for (int i = 0; i < 60; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = a + 32'(4 * DEPTH);
      op(1'($urandom), a, $urandom, 4'($urandom), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
